serial_rx_burst_master: RTL and testbench
=========================================

# serial_rx_burst_master

Parametrised master-side receive port for the serial bus. On a read instruction it accepts a burst of `burst_num+1` words from a slave over `LANES` parallel serial lines. It uses a valid/ready handshake per word and assembles each word in configurable bit order. Completed words are buffered in an internal first-word-fall-through FIFO, which presents them to the downstream consumer with a valid/ready interface. Back-pressure from the FIFO throttles the serial handshake.

## Interface
- `DATA_LEN`, 8: bits per word; must be a multiple of `LANES`.
- `BURST_LEN`, 12: width of `burst_num`.
- `LANES`, 1: serial lines sampled per cycle; allowed values 1, 2, 4, 8.
- `FIFO_DEPTH`, 4: output FIFO entries; power of 2, ≥2.
- `MSB_FIRST`, 0: 0 = LSB of the word arrives first; 1 = MSB arrives first.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `instruction` in 2: 2'b11 = start read; 2'b01 = abort; other codes are ignored.
- `burst_num` in BURST_LEN: word count minus 1; sampled at start.
- `rx_data` in LANES: serial data from the slave.
- `slave_valid` in 1: slave has a word ready to send.
- `master_ready` out 1: master can accept a word.
- `data_out` out DATA_LEN: FIFO head word; 0 when the FIFO is empty.
- `data_valid` out 1: FIFO is not empty.
- `data_ready` in 1: consumer accepts the head word.
- `fifo_level` out $clog2(FIFO_DEPTH+1): number of FIFO entries occupied.
- `busy` out 1: a burst is in progress.
- `rx_done` out 1: one-cycle pulse when a burst completes.

## Operation
- BEATS = DATA_LEN/LANES. beat counter: 0..BEATS-1. word counter: BURST_LEN+1 bits.
- Bit mapping, beat k, lane j:
  - MSB_FIRST=0: bit k·LANES+j.
  - MSB_FIRST=1: bit DATA_LEN-1-(k·LANES+j).
- States: IDLE, WAIT_HANDSHAKE, RECEIVE.
- IDLE:
  - `busy`=0.
  - instruction==2'b11 → latch `burst_num`, clear counters → WAIT_HANDSHAKE.
- WAIT_HANDSHAKE:
  - `master_ready` = !FIFO full. It is combinational from registered state and level, and is 0 in every other state.
  - `slave_valid && master_ready` captures beat 0.
  - If BEATS==1, the word completes in this cycle; otherwise → RECEIVE.
- RECEIVE:
  - Captures beats 1..BEATS-1 unconditionally, one per cycle; `slave_valid` is ignored.
  - The last beat completes the word.
- Word complete:
  - The fully assembled word, including the last beat's bits, is pushed into the FIFO at that edge.
  - If word counter == latched burst_num → IDLE, and `rx_done`=1 for the next cycle.
  - Otherwise increment the word counter → WAIT_HANDSHAKE.
- instruction==2'b11 while busy: ignored.
- instruction==2'b01 while busy:
  - Next state IDLE; the partial word is discarded.
  - FIFO contents are kept; no `rx_done`.
  - Abort takes priority over a same-cycle word completion; that word is discarded.
- FIFO:
  - Pop when `data_valid && data_ready`.
  - Simultaneous push and pop leaves the level unchanged; the head advances in order.
  - Overflow is impossible: a word is only started when not full, and nothing else pushes during its reception.
  - Popping when empty has no effect.
- burst_num=0 → one word. Max burst = 2^BURST_LEN words; the word counter's extra bit prevents wrap.

## Timing
- Reset values: state IDLE, FIFO empty, `master_ready`=0, `data_valid`=0, `data_out`=0, `fifo_level`=0, `busy`=0, `rx_done`=0, counters 0.
- Reset mid-burst discards the partial word and all FIFO contents.
- Start → `master_ready` high: 1 cycle after the cycle instruction==2'b11 is sampled.
- Word latency: the handshake cycle plus BEATS-1 cycles. `data_valid` rises the cycle after the last beat, when the FIFO was empty.
- With `slave_valid` held high and the FIFO draining, sustained throughput is one word per BEATS cycles. The handshake for word n+1 falls in the cycle immediately after word n's last beat.
- `busy` goes high the cycle after start and falls with the transition to IDLE, in the same cycle `rx_done` asserts.

## Test plan
- DATA_LEN=8, LANES=1, MSB_FIRST=0: burst_num=0, serial bits of 0xA5 sent LSB-first.
  - `data_out`=0xA5, `data_valid` 9 cycles after start; `rx_done` one pulse; `busy` 0.
- LANES=2, MSB_FIRST=1: burst_num=2, words 0x3C, 0xF0, 0x81.
  - Each word takes 4 cycles; FIFO order is 0x3C, 0xF0, 0x81; `fifo_level` reaches 3; a single `rx_done`.
- Back-pressure, FIFO_DEPTH=4, `data_ready`=0: burst_num=5.
  - `master_ready` stays 0 after 4 words, with `fifo_level`=4.
  - Raising `data_ready` for 1 cycle gives level 3 and `master_ready` 1 the next cycle; the 5th word then lands.
- `slave_valid` low for 3 cycles between words:
  - The FSM holds in WAIT_HANDSHAKE with `master_ready`=1 and no bit capture; the data is still correct.
- Abort after 3 beats of word 2 (burst_num=3):
  - IDLE next cycle; the FIFO holds only word 1; no `rx_done`; a new start then works.
- Reset asserted mid-word with 2 words in the FIFO:
  - Every output returns to its reset value on the next edge.
- Simultaneous push and pop with FIFO at level 2:
  - Level stays 2; word order is preserved.

Source files
------------

// File: rtl/serial_rx_burst_master.sv
// serial_rx_burst_master
// Master-side receive port: accepts a burst of words from a slave over LANES
// serial lines. Each word starts with a slave_valid/master_ready handshake.
// Completed words queue in a first-word-fall-through FIFO for the consumer.
module serial_rx_burst_master #(
    parameter int unsigned DATA_LEN   = 8,
    parameter int unsigned BURST_LEN  = 12,
    parameter int unsigned LANES      = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MSB_FIRST  = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [1:0]                      instruction,
    input  logic [BURST_LEN-1:0]            burst_num,
    input  logic [LANES-1:0]                rx_data,
    input  logic                            slave_valid,
    output logic                            master_ready,
    output logic [DATA_LEN-1:0]             data_out,
    output logic                            data_valid,
    input  logic                            data_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            busy,
    output logic                            rx_done
);

    localparam int unsigned BEATS = DATA_LEN / LANES;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [DATA_LEN-1:0] ONE = DATA_LEN'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HANDSHAKE,
        RECEIVE
    } state_t;

    state_t               state, state_nxt;
    logic [BURST_LEN-1:0] burst_lat;
    logic [BURST_LEN:0]   word_cnt;
    logic [BW-1:0]        beat_cnt;
    logic [DATA_LEN-1:0]  word_buf;
    logic [DATA_LEN-1:0]  assembled;
    logic                 rx_done_q;

    logic                 start, abort, capture, word_done, push, pop, last_word, full;
    int unsigned          pos;
    logic [LANES-1:0]     lane_bits;

    logic [DATA_LEN-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level;

    assign start     = (state == IDLE) && (instruction == 2'b11);
    assign abort     = (state != IDLE) && (instruction == 2'b01);
    assign last_word = (word_cnt == {1'b0, burst_lat});
    assign full      = (level == LW'(FIFO_DEPTH));
    assign push      = word_done && !abort;
    assign pop       = data_valid && data_ready;

    // Current word with this cycle's lane bits merged in at their beat position
    always_comb begin
        assembled = word_buf;
        pos       = 0;
        lane_bits = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            pos = 32'(beat_cnt) * LANES + j;
            if (MSB_FIRST != 0) pos = DATA_LEN - 1 - pos;
            lane_bits = rx_data >> j;
            assembled = (assembled & ~(ONE << pos)) | (DATA_LEN'(lane_bits[0]) << pos);
        end
    end

    // Next-state logic; abort overrides any same-cycle word completion
    always_comb begin
        state_nxt    = state;
        capture      = 1'b0;
        word_done    = 1'b0;
        master_ready = 1'b0;
        case (state)
            IDLE: begin
                if (instruction == 2'b11) state_nxt = WAIT_HANDSHAKE;
            end
            WAIT_HANDSHAKE: begin
                master_ready = !full;
                if (slave_valid && !full) begin
                    capture = 1'b1;
                    if (BEATS == 1) word_done = 1'b1;
                    else            state_nxt = RECEIVE;
                end
            end
            RECEIVE: begin
                capture = 1'b1;
                if (beat_cnt == BW'(BEATS - 1)) word_done = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (word_done) state_nxt = last_word ? IDLE : WAIT_HANDSHAKE;
        if (abort)     state_nxt = IDLE;
    end

    // FSM state, burst counters and word assembly register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            burst_lat <= '0;
            word_cnt  <= '0;
            beat_cnt  <= '0;
            word_buf  <= '0;
            rx_done_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            rx_done_q <= push && last_word;
            if (start) begin
                burst_lat <= burst_num;
                word_cnt  <= '0;
            end else if (push && !last_word) begin
                word_cnt  <= word_cnt + 1'b1;
            end
            // beat counter only runs while the next cycle is still mid-word
            if (state_nxt != RECEIVE) beat_cnt <= '0;
            else if (capture)         beat_cnt <= beat_cnt + 1'b1;
            if (capture) word_buf <= assembled;
        end
    end

    // Output FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // FIFO storage; contents are qualified by level so need no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= assembled;
    end

    assign data_valid = (level != '0);
    assign data_out   = data_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;
    assign busy       = (state != IDLE);
    assign rx_done    = rx_done_q;

endmodule

// File: tb/tb_serial_rx_burst_master.sv
// Directed bench for serial_rx_burst_master: one LSB-first single-lane
// instance and one MSB-first two-lane instance sharing clock and reset.
`timescale 1ns/1ps
module tb_serial_rx_burst_master;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]  a_instr, b_instr;
    logic [11:0] a_burst, b_burst;
    logic [0:0]  a_rx;
    logic [1:0]  b_rx;
    logic        a_sv, a_mr, a_dv, a_dr, a_busy, a_done;
    logic        b_sv, b_mr, b_dv, b_dr, b_busy, b_done;
    logic [7:0]  a_do, b_do;
    logic [2:0]  a_lvl, b_lvl;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int c0;

    serial_rx_burst_master #(.DATA_LEN(8), .BURST_LEN(12), .LANES(1), .FIFO_DEPTH(4), .MSB_FIRST(0)) dut_a (
        .clk(clk), .reset(reset), .instruction(a_instr), .burst_num(a_burst),
        .rx_data(a_rx), .slave_valid(a_sv), .master_ready(a_mr),
        .data_out(a_do), .data_valid(a_dv), .data_ready(a_dr),
        .fifo_level(a_lvl), .busy(a_busy), .rx_done(a_done)
    );

    serial_rx_burst_master #(.DATA_LEN(8), .BURST_LEN(12), .LANES(2), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut_b (
        .clk(clk), .reset(reset), .instruction(b_instr), .burst_num(b_burst),
        .rx_data(b_rx), .slave_valid(b_sv), .master_ready(b_mr),
        .data_out(b_do), .data_valid(b_dv), .data_ready(b_dr),
        .fifo_level(b_lvl), .busy(b_busy), .rx_done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_a(input logic [11:0] n);
        a_burst = n;
        a_instr = 2'b11;
        tick();
        a_instr = 2'b00;
    endtask

    // LSB-first single-lane word; optionally pop on the edge that pushes it
    task automatic send_a(input logic [7:0] w, input logic pop_last);
        int n = 0;
        a_rx = w[0];
        a_sv = 1'b1;
        while (!a_mr && n < 200) begin
            tick();
            n++;
        end
        chk("a_handshake_wait", 32'(n < 200), 32'd1);
        for (int k = 1; k < 8; k++) begin
            tick();
            a_sv = 1'b0;
            a_rx = 1'(w >> k);
        end
        a_dr = pop_last;
        tick();
        a_dr = 1'b0;
    endtask

    // MSB-first two-lane word: lane0 carries the higher bit of each pair
    task automatic send_b(input logic [7:0] w, input logic [2:0] lvl0);
        int n = 0;
        logic [7:0] t;
        t    = w;
        b_rx = {t[6], t[7]};
        b_sv = 1'b1;
        while (!b_mr && n < 200) begin
            tick();
            n++;
        end
        chk("b_handshake_wait", 32'(n < 200), 32'd1);
        for (int k = 1; k < 4; k++) begin
            tick();
            b_sv = 1'b0;
            t    = t << 2;
            b_rx = {t[6], t[7]};
        end
        chk("b_level_before_last_edge", 32'(b_lvl), 32'(lvl0));
        tick();
        chk("b_level_after_word", 32'(b_lvl), 32'(lvl0) + 1);
    endtask

    task automatic pop_a(input logic [7:0] exp);
        chk("a_pop_head", 32'(a_do), 32'(exp));
        a_dr = 1'b1;
        tick();
        a_dr = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_instr = '0; a_burst = '0; a_rx = '0; a_sv = 1'b0; a_dr = 1'b0;
        b_instr = '0; b_burst = '0; b_rx = '0; b_sv = 1'b0; b_dr = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // reset state
        chk("rst_a_mr", 32'(a_mr), 0);
        chk("rst_a_dv", 32'(a_dv), 0);
        chk("rst_a_do", 32'(a_do), 0);
        chk("rst_a_lvl", 32'(a_lvl), 0);
        chk("rst_a_busy", 32'(a_busy), 0);
        chk("rst_a_done", 32'(a_done), 0);
        chk("rst_b_mr", 32'(b_mr), 0);
        chk("rst_b_busy", 32'(b_busy), 0);

        // single word 0xA5, LSB first
        c0 = cyc;
        start_a(12'd0);
        chk("t1_mr_after_start", 32'(a_mr), 1);
        chk("t1_busy", 32'(a_busy), 1);
        send_a(8'hA5, 1'b0);
        chk("t1_latency", 32'(cyc - c0), 9);
        chk("t1_dv", 32'(a_dv), 1);
        chk("t1_do", 32'(a_do), 32'h A5);
        chk("t1_done", 32'(a_done), 1);
        chk("t1_busy_low", 32'(a_busy), 0);
        tick();
        chk("t1_done_pulse", 32'(a_done), 0);
        pop_a(8'hA5);
        chk("t1_empty_dv", 32'(a_dv), 0);
        chk("t1_empty_do", 32'(a_do), 0);

        // two lanes, MSB first, three words
        b_burst = 12'd2;
        b_instr = 2'b11;
        tick();
        b_instr = 2'b00;
        send_b(8'h3C, 3'd0);
        chk("t2_done_w1", 32'(b_done), 0);
        send_b(8'hF0, 3'd1);
        chk("t2_done_w2", 32'(b_done), 0);
        send_b(8'h81, 3'd2);
        chk("t2_done_w3", 32'(b_done), 1);
        chk("t2_busy", 32'(b_busy), 0);
        chk("t2_level", 32'(b_lvl), 3);
        tick();
        chk("t2_done_pulse", 32'(b_done), 0);
        chk("t2_head0", 32'(b_do), 32'h3C);
        b_dr = 1'b1;
        tick();
        chk("t2_head1", 32'(b_do), 32'hF0);
        tick();
        chk("t2_head2", 32'(b_do), 32'h81);
        tick();
        b_dr = 1'b0;
        chk("t2_drained", 32'(b_lvl), 0);

        // back-pressure with a full FIFO
        start_a(12'd5);
        send_a(8'h11, 1'b0);
        send_a(8'h22, 1'b0);
        send_a(8'h33, 1'b0);
        send_a(8'h44, 1'b0);
        chk("t3_full_lvl", 32'(a_lvl), 4);
        chk("t3_full_mr", 32'(a_mr), 0);
        chk("t3_busy", 32'(a_busy), 1);
        a_sv = 1'b1;
        tick(); tick();
        chk("t3_mr_held_low", 32'(a_mr), 0);
        a_sv = 1'b0;
        pop_a(8'h11);
        chk("t3_lvl_after_pop", 32'(a_lvl), 3);
        chk("t3_mr_after_pop", 32'(a_mr), 1);
        send_a(8'h55, 1'b0);
        chk("t3_fifth_lvl", 32'(a_lvl), 4);
        pop_a(8'h22);
        pop_a(8'h33);
        pop_a(8'h44);
        pop_a(8'h55);
        chk("t3_drained", 32'(a_lvl), 0);
        send_a(8'h66, 1'b0);
        chk("t3_done", 32'(a_done), 1);
        pop_a(8'h66);

        // slave_valid low for three cycles between words
        start_a(12'd1);
        send_a(8'hC3, 1'b0);
        chk("t4_done_mid", 32'(a_done), 0);
        for (int i = 0; i < 3; i++) begin
            chk("t4_gap_mr", 32'(a_mr), 1);
            a_rx = ~a_rx;
            tick();
        end
        send_a(8'h5A, 1'b0);
        chk("t4_done", 32'(a_done), 1);
        pop_a(8'hC3);
        pop_a(8'h5A);
        chk("t4_drained", 32'(a_lvl), 0);

        // abort after three beats of word 2
        start_a(12'd3);
        send_a(8'hE7, 1'b0);
        a_sv = 1'b1;
        a_rx = 1'b0;
        tick();
        a_sv = 1'b0;
        a_rx = 1'b1;
        tick();
        a_rx = 1'b1;
        tick();
        a_instr = 2'b01;
        tick();
        a_instr = 2'b00;
        chk("t5_busy", 32'(a_busy), 0);
        chk("t5_mr", 32'(a_mr), 0);
        chk("t5_lvl", 32'(a_lvl), 1);
        chk("t5_head", 32'(a_do), 32'hE7);
        chk("t5_no_done", 32'(a_done), 0);
        tick();
        chk("t5_no_done_later", 32'(a_done), 0);
        start_a(12'd0);
        send_a(8'h69, 1'b0);
        chk("t5_restart_done", 32'(a_done), 1);
        chk("t5_restart_lvl", 32'(a_lvl), 2);
        pop_a(8'hE7);
        pop_a(8'h69);

        // reset mid-word with two words buffered
        start_a(12'd3);
        send_a(8'h01, 1'b0);
        send_a(8'h02, 1'b0);
        a_rx = 1'b1;
        a_sv = 1'b1;
        tick();
        a_sv = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("t6_mr", 32'(a_mr), 0);
        chk("t6_dv", 32'(a_dv), 0);
        chk("t6_do", 32'(a_do), 0);
        chk("t6_lvl", 32'(a_lvl), 0);
        chk("t6_busy", 32'(a_busy), 0);
        chk("t6_done", 32'(a_done), 0);
        reset = 1'b0;
        tick();
        chk("t6_still_idle", 32'(a_busy), 0);

        // simultaneous push and pop at level 2
        start_a(12'd2);
        send_a(8'h10, 1'b0);
        send_a(8'h20, 1'b0);
        chk("t7_lvl_before", 32'(a_lvl), 2);
        send_a(8'h30, 1'b1);
        chk("t7_lvl_same", 32'(a_lvl), 2);
        chk("t7_done", 32'(a_done), 1);
        pop_a(8'h20);
        pop_a(8'h30);
        chk("t7_drained", 32'(a_lvl), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
